// File: rtl/binary_to_bcd_encoder.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-add-3 iteration per clock.
// Start/busy/done handshake; bcd and overflow hold their value between conversions.
module binary_to_bcd_encoder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic [WIDTH-1:0]   shift_nxt;
    logic               carry_out;

    // One iteration: per-digit add-3 (no inter-digit carry), then shift {scratch, shift} left.
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        carry_out   = adj[BCD_W-1];
        scratch_nxt = {adj[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_nxt   = shift_q << 1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d   = shift_nxt;
                scratch_d = scratch_nxt;
                ovf_acc_d = ovf_acc_q | carry_out;
                cnt_d     = cnt_q + CNT_W'(1);
                // Last iteration: publish result including this iteration's carry-out.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    bcd_d      = scratch_nxt;
                    overflow_d = ovf_acc_q | carry_out;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
